gesture_score_engine: RTL and testbench
=======================================

# gesture_score_engine

Downstream consumer of the per-class weight RAMs in the voxel-bin architecture. On a `start` pulse it scans every voxel cell address once, driving a shared `cell_addr` to the voxel-count memory and all class weight RAMs. It multiply-accumulates count × weight per class, then runs a sequential argmax. It presents the winning gesture class and its score on a valid/ready result port.

## Interface
Parameters:
- `NUM_CLASSES`, 4: gesture classes (UP=0, DOWN=1, LEFT=2, RIGHT=3).
- `NUM_CELLS`, 1024: cells scanned per frame (bins × GRID_SIZE²).
- `WEIGHT_BITS`, 8: signed weight width.
- `COUNT_BITS`, 8: unsigned voxel count width.
- `ACC_BITS`, 28: signed accumulator width.
  - Elaboration error if `ACC_BITS` < WEIGHT_BITS+COUNT_BITS+$clog2(NUM_CELLS)+1.
- `MIN_MARGIN`, 64: minimum best-minus-second score for a confident result (used only under the macro).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `cell_addr` out $clog2(NUM_CELLS): read address shared by voxel memory and weight RAMs.
- `voxel_count` in COUNT_BITS: unsigned; valid one cycle after `cell_addr`.
- `weight_in` in NUM_CLASSES×WEIGHT_BITS: packed signed weights.
  - Class c occupies bits [c*WEIGHT_BITS +: WEIGHT_BITS].
  - Valid one cycle after `cell_addr`.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_class` out $clog2(NUM_CLASSES): winning class index.
- `result_score` out ACC_BITS: signed score of the winner.
- `result_confident` out 1: margin check passed.

## Operation
- FSM states: IDLE, SCAN, DRAIN, ARGMAX, DONE.
- IDLE:
  - `cell_addr`=0; accumulators hold their previous values.
  - `start`=1 clears all accumulators and moves to SCAN with address counter at 0.
- SCAN:
  - Drives `cell_addr`=counter, incrementing 0..NUM_CELLS-1, one address per cycle.
  - Each cycle, data for the previous address is accumulated: acc[c] += signed(weight_in[c]) × zero-extended `voxel_count`.
  - After issuing address NUM_CELLS-1, moves to DRAIN.
- DRAIN:
  - One cycle; accumulates data for the last address.
  - `cell_addr` returns to 0.
- ARGMAX:
  - Iterates c = 0..NUM_CLASSES-1, one class per cycle.
  - Replaces the best candidate only when acc[c] > best (strict), so ties resolve to the lowest index.
  - Also tracks the second-best score.
- DONE:
  - `result_valid`=1; all result outputs held stable until `result_ready`=1.
  - The transfer completes on a cycle where `result_valid` and `result_ready` are both 1; the FSM then returns to IDLE and `result_valid` falls the next cycle.
- `start` is ignored outside IDLE, including in DONE.
- `rst` at any point, including mid-scan:
  - Returns the FSM to IDLE, clears accumulators, and discards any pending result.
- The block never writes the weight RAMs; their write enables are tied low at the parent.

## Timing
- Reset values: `busy`=0, `cell_addr`=0, `result_valid`=0, `result_class`=0, `result_score`=0, `result_confident`=0.
- With `start` sampled at edge T:
  - Address 0 appears during cycle T+1.
  - Address NUM_CELLS-1 appears during cycle T+NUM_CELLS.
  - DRAIN occupies cycle T+NUM_CELLS+1.
  - ARGMAX occupies cycles T+NUM_CELLS+2 .. T+NUM_CELLS+NUM_CLASSES+1.
  - `result_valid` rises at T+NUM_CELLS+NUM_CLASSES+2, i.e. T+1030 with default parameters.
- Upstream read latency is exactly 1 cycle; RAM `dout` must not be gated by an enable.
- `busy` is high from T+1 through the result-accept cycle.
- The earliest next `start` is the cycle after the accept.

## Configuration
- `GESTURE_CONFIDENCE_EN` defined:
  - ARGMAX tracks the second-best score.
  - `result_confident` = (best − second) ≥ MIN_MARGIN.
  - With NUM_CLASSES=1, `result_confident`=1.
- Not defined:
  - No second-best logic is built.
  - `result_confident` is 1 whenever `result_valid`=1.

## Structure
- Shared package `gesture_pkg` holds:
  - The class enum (UP, DOWN, LEFT, RIGHT) and `NUM_CLASSES`.
  - The FSM state typedef.
  - The accumulator width rule as a localparam function.
- One sub-module, `class_mac`, instantiated NUM_CLASSES times:
  - Ports: `clk`, `rst`, clear, enable, signed weight, unsigned count, ACC_BITS accumulator.
  - Contains the signed×unsigned product and the registered accumulate.

## Test plan
- All counts 0, any weights, `start` → all scores 0, `result_class`=0 (tie to lowest index), `result_score`=0; `result_confident`=0 with the macro.
- Count 10 at address 0 only, weights at address 0 = {+5, −3, −3, −3} for class 2 and −3 elsewhere → `result_class`=2, `result_score`=50, `result_valid` rises exactly 1030 cycles after `start`.
- All counts 255, class 3 weights +127, others −128 everywhere → `result_class`=3, `result_score`=33,162,240 with no overflow; class 0 accumulator = −33,423,360.
- `result_ready` held low 20 cycles with `start` pulsed during DONE → outputs stable, `start` ignored; accept at cycle 21 → IDLE, `result_valid` low next cycle.
- `rst` asserted while `cell_addr`=500 → next cycle IDLE, `busy`=0, `result_valid`=0; a fresh scan gives a result identical to the no-reset reference.
- Macro on, scores {100, 90, 0, 0} with MIN_MARGIN=64 → `result_class`=0, `result_confident`=0; scores {200, 90, 0, 0} → `result_confident`=1.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture scoring engine.
package gesture_pkg;

    localparam int unsigned NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } gesture_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_ARGMAX,
        ST_DONE
    } state_e;

    // Accumulator width that cannot overflow: product width plus one bit per doubling of cells.
    function automatic int unsigned min_acc_bits(input int unsigned weight_bits,
                                                 input int unsigned count_bits,
                                                 input int unsigned num_cells);
        return weight_bits + count_bits + $clog2(num_cells) + 1;
    endfunction

endpackage

// File: rtl/class_mac.sv
// Per-class multiply-accumulate: signed weight times unsigned voxel count.
module class_mac
    import gesture_pkg::*;
#(
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned COUNT_BITS  = 8,
    parameter int unsigned ACC_BITS    = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          enable_i,
    input  logic signed [WEIGHT_BITS-1:0] weight_i,
    input  logic        [COUNT_BITS-1:0]  count_i,
    output logic signed [ACC_BITS-1:0]    acc_o
);

    localparam int unsigned PROD_BITS = WEIGHT_BITS + COUNT_BITS + 1;

    logic signed [PROD_BITS-1:0] prod_c;
    logic signed [ACC_BITS-1:0]  acc_q;

    // Count is zero-extended by one bit so the product stays a signed multiply.
    assign prod_c = PROD_BITS'(weight_i) * PROD_BITS'($signed({1'b0, count_i}));

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (enable_i) begin
            acc_q <= acc_q + ACC_BITS'(prod_c);
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/gesture_score_engine.sv
// Scans all voxel cells, accumulates count x weight per class, then picks the
// highest-scoring class. Optional margin check enabled by GESTURE_CONFIDENCE_EN.
module gesture_score_engine
    import gesture_pkg::state_e;
    import gesture_pkg::ST_IDLE;
    import gesture_pkg::ST_SCAN;
    import gesture_pkg::ST_DRAIN;
    import gesture_pkg::ST_ARGMAX;
    import gesture_pkg::ST_DONE;
    import gesture_pkg::min_acc_bits;
#(
    parameter int unsigned NUM_CLASSES = gesture_pkg::NUM_CLASSES,
    parameter int unsigned NUM_CELLS   = 1024,
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned COUNT_BITS  = 8,
    parameter int unsigned ACC_BITS    = 28,
    parameter int unsigned MIN_MARGIN  = 64,
    localparam int unsigned ADDR_W     = $clog2(NUM_CELLS),
    localparam int unsigned CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic [ADDR_W-1:0]                   cell_addr,
    input  logic [COUNT_BITS-1:0]               voxel_count,
    input  logic [NUM_CLASSES*WEIGHT_BITS-1:0]  weight_in,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [CLS_W-1:0]                    result_class,
    output logic signed [ACC_BITS-1:0]          result_score,
    output logic                                result_confident
);

    // Elaboration-time guards on parameter combinations.
    if (ACC_BITS < min_acc_bits(WEIGHT_BITS, COUNT_BITS, NUM_CELLS)) begin : g_acc_too_narrow
        $error("ACC_BITS too narrow for worst-case accumulation");
    end
    if ($clog2(MIN_MARGIN + 1) > ACC_BITS) begin : g_margin_too_wide
        $error("MIN_MARGIN does not fit in ACC_BITS");
    end

    localparam int unsigned MARGIN_W = ACC_BITS + 1;

    state_e                      state_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [CLS_W-1:0]            cls_q;
    logic signed [ACC_BITS-1:0]  best_q;
    logic [CLS_W-1:0]            best_idx_q;
    logic                        busy_q;
    logic                        valid_q;
    logic [CLS_W-1:0]            class_q;
    logic signed [ACC_BITS-1:0]  score_q;
    logic                        conf_q;

    logic signed [ACC_BITS-1:0]  acc [NUM_CLASSES];
    logic                        mac_clear_c;
    logic                        mac_en_c;
    logic signed [ACC_BITS-1:0]  cand_c;
    logic signed [ACC_BITS-1:0]  best_d;
    logic [CLS_W-1:0]            best_idx_d;
    logic                        conf_c;

`ifdef GESTURE_CONFIDENCE_EN
    localparam logic signed [ACC_BITS-1:0] ACC_MIN    = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [MARGIN_W-1:0] MARGIN_MIN = MARGIN_W'(MIN_MARGIN);

    logic signed [ACC_BITS-1:0]  second_q;
    logic signed [ACC_BITS-1:0]  second_d;
    logic signed [MARGIN_W-1:0]  margin_c;
`endif

    // Accumulators clear on an accepted start; data lags the address by one cycle,
    // so the first SCAN cycle has nothing to add and DRAIN adds the last cell.
    assign mac_clear_c = (state_q == ST_IDLE) && start;
    assign mac_en_c    = ((state_q == ST_SCAN) && (addr_q != '0)) || (state_q == ST_DRAIN);

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_mac
        class_mac #(
            .WEIGHT_BITS (WEIGHT_BITS),
            .COUNT_BITS  (COUNT_BITS),
            .ACC_BITS    (ACC_BITS)
        ) u_mac (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (mac_clear_c),
            .enable_i (mac_en_c),
            .weight_i (weight_in[c*WEIGHT_BITS +: WEIGHT_BITS]),
            .count_i  (voxel_count),
            .acc_o    (acc[c])
        );
    end

    assign cand_c = acc[cls_q];

    // Argmax step for the class currently selected; strict compare keeps the lowest index on ties.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
`ifdef GESTURE_CONFIDENCE_EN
        second_d   = second_q;
`endif
        if (cls_q == '0) begin
            best_d     = cand_c;
            best_idx_d = '0;
`ifdef GESTURE_CONFIDENCE_EN
            second_d   = ACC_MIN;
`endif
        end else if (cand_c > best_q) begin
            best_d     = cand_c;
            best_idx_d = cls_q;
`ifdef GESTURE_CONFIDENCE_EN
            second_d   = best_q;
        end else if (cand_c > second_q) begin
            second_d   = cand_c;
`endif
        end
    end

`ifdef GESTURE_CONFIDENCE_EN
    // Margin is computed one bit wider so best minus second never wraps.
    assign margin_c = MARGIN_W'(best_d) - MARGIN_W'(second_d);
    assign conf_c   = (NUM_CLASSES == 1) || (margin_c >= MARGIN_MIN);
`else
    assign conf_c   = 1'b1;
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cls_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            score_q    <= '0;
            conf_q     <= 1'b0;
`ifdef GESTURE_CONFIDENCE_EN
            second_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_q <= '0;
                    if (start) begin
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (addr_q == ADDR_W'(NUM_CELLS - 1)) begin
                        state_q <= ST_DRAIN;
                        addr_q  <= '0;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_ARGMAX;
                    cls_q   <= '0;
                end
                ST_ARGMAX: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
`ifdef GESTURE_CONFIDENCE_EN
                    second_q   <= second_d;
`endif
                    if (cls_q == CLS_W'(NUM_CLASSES - 1)) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                        class_q <= best_idx_d;
                        score_q <= best_d;
                        conf_q  <= conf_c;
                    end else begin
                        cls_q   <= cls_q + CLS_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign cell_addr        = addr_q;
    assign result_valid     = valid_q;
    assign result_class     = class_q;
    assign result_score     = score_q;
    assign result_confident = conf_q;

endmodule

// File: tb/tb_gesture_score_engine.sv
// Self-checking bench for gesture_score_engine: table vectors, corner sequences, random frames.
module tb_gesture_score_engine;

    localparam int NC     = 4;
    localparam int NCELL  = 1024;
    localparam int WB     = 8;
    localparam int CB     = 8;
    localparam int AB     = 28;
    localparam int MARGIN = 64;
    localparam int LAT    = NCELL + NC + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic [9:0]           cell_addr;
    logic [CB-1:0]        voxel_count;
    logic [NC*WB-1:0]     weight_in;
    logic                 result_valid;
    logic                 result_ready;
    logic [1:0]           result_class;
    logic signed [AB-1:0] result_score;
    logic                 result_confident;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gesture_score_engine #(
        .NUM_CLASSES (NC),
        .NUM_CELLS   (NCELL),
        .WEIGHT_BITS (WB),
        .COUNT_BITS  (CB),
        .ACC_BITS    (AB),
        .MIN_MARGIN  (MARGIN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .cell_addr        (cell_addr),
        .voxel_count      (voxel_count),
        .weight_in        (weight_in),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_class     (result_class),
        .result_score     (result_score),
        .result_confident (result_confident)
    );

    // Upstream memories with one-cycle read latency.
    logic [CB-1:0]    cnt_mem [NCELL];
    logic [NC*WB-1:0] wgt_mem [NCELL];

    always @(posedge clk) begin
        voxel_count <= cnt_mem[cell_addr];
        weight_in   <= wgt_mem[cell_addr];
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    // Reference model: plain sums over the memories, then argmax and runner-up.
    longint m_score [NC];
    int     m_class;
    bit     m_conf;

    task automatic model();
        longint second;
        logic signed [WB-1:0] w;
        for (int c = 0; c < NC; c++) begin
            m_score[c] = 0;
            for (int i = 0; i < NCELL; i++) begin
                w = wgt_mem[i][c*WB +: WB];
                m_score[c] += longint'(cnt_mem[i]) * longint'(w);
            end
        end
        m_class = 0;
        for (int c = 1; c < NC; c++) if (m_score[c] > m_score[m_class]) m_class = c;
        second = -(64'sd1 <<< 62);
        for (int c = 0; c < NC; c++) if (c != m_class && m_score[c] > second) second = m_score[c];
`ifdef GESTURE_CONFIDENCE_EN
        m_conf = (m_score[m_class] - second) >= MARGIN;
`else
        m_conf = 1'b1;
`endif
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < NCELL; i++) begin
            wgt_mem[i] = $urandom();
            case (kind)
                2: begin
                    cnt_mem[i] = 8'd255;
                    wgt_mem[i] = {8'h7F, 8'h80, 8'h80, 8'h80};
                end
                5: cnt_mem[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
                6: cnt_mem[i] = 8'($urandom_range(0, 255));
                default: cnt_mem[i] = 8'd0;
            endcase
        end
        case (kind)
            1: begin cnt_mem[0] = 8'd10; wgt_mem[0] = {8'hFD, 8'h05, 8'hFD, 8'hFD}; end
            3: begin cnt_mem[0] = 8'd10; wgt_mem[0] = {8'h00, 8'h00, 8'h09, 8'h0A}; end
            4: begin cnt_mem[0] = 8'd10; wgt_mem[0] = {8'h00, 8'h00, 8'h09, 8'h14}; end
            default: ;
        endcase
    endtask

    logic [1:0]           f_class;
    logic signed [AB-1:0] f_score;
    logic                 f_conf;

    // One full frame: start, check address sequence and latency, optionally hold DONE, accept.
    task automatic run_frame(input string tag, input bit hold);
        int lat;
        int addr_err;
        int busy_err;
        int exp_addr;
        bit stable;
        addr_err = 0;
        busy_err = 0;
        stable   = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 1;
        while (result_valid !== 1'b1 && lat < LAT + 50) begin
            if (busy !== 1'b1) busy_err++;
            exp_addr = (lat <= NCELL) ? lat - 1 : 0;
            if (cell_addr !== 10'(exp_addr)) addr_err++;
            @(posedge clk); #1 lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_addr_seq_errs"}, addr_err, 0);
        chk({tag, "_busy_errs"}, busy_err, 0);
        f_class = result_class;
        f_score = result_score;
        f_conf  = result_confident;
        if (hold) begin
            for (int i = 1; i <= 20; i++) begin
                if (i == 5) start = 1'b1;
                if (i == 6) start = 1'b0;
                @(posedge clk); #1;
                if (result_valid !== 1'b1 || result_class !== f_class || result_score !== f_score ||
                    result_confident !== f_conf || busy !== 1'b1) stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, longint'(stable), 1);
        end
        result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;
        chk({tag, "_valid_after_accept"}, longint'(result_valid), 0);
        chk({tag, "_busy_after_accept"}, longint'(busy), 0);
        if (hold) begin
            repeat (3) @(posedge clk);
            #1 chk({tag, "_start_ignored_busy"}, longint'(busy), 0);
        end
    endtask

    typedef struct {
        int     kind;
        int     exp_class;
        longint exp_score;
        bit     exp_conf_on;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit   found;
        logic exp_conf;
        vecs[0] = '{kind: 0, exp_class: 0, exp_score: 0,        exp_conf_on: 1'b0};
        vecs[1] = '{kind: 1, exp_class: 2, exp_score: 50,       exp_conf_on: 1'b1};
        vecs[2] = '{kind: 2, exp_class: 3, exp_score: 33162240, exp_conf_on: 1'b1};
        vecs[3] = '{kind: 3, exp_class: 0, exp_score: 100,      exp_conf_on: 1'b0};
        vecs[4] = '{kind: 4, exp_class: 0, exp_score: 200,      exp_conf_on: 1'b1};

        rst = 1'b1; start = 1'b0; result_ready = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_cell_addr", longint'(cell_addr), 0);
        chk("rst_valid", longint'(result_valid), 0);
        chk("rst_class", longint'(result_class), 0);
        chk("rst_score", longint'(result_score), 0);
        chk("rst_conf", longint'(result_confident), 0);
        rst = 1'b0;

        // Directed table vectors.
        for (int k = 0; k < 5; k++) begin
            fill(vecs[k].kind);
            run_frame($sformatf("v%0d", k), 1'b0);
`ifdef GESTURE_CONFIDENCE_EN
            exp_conf = vecs[k].exp_conf_on;
`else
            exp_conf = 1'b1;
`endif
            chk($sformatf("v%0d_class", k), longint'(f_class), vecs[k].exp_class);
            chk($sformatf("v%0d_score", k), longint'(f_score), vecs[k].exp_score);
            chk($sformatf("v%0d_conf", k), longint'(f_conf), longint'(exp_conf));
            if (vecs[k].kind == 2)
                chk("v2_acc0", longint'(dut.g_mac[0].u_mac.acc_o), -64'sd33423360);
        end

        // DONE held for 20 cycles with a start pulse that must be ignored.
        fill(5);
        model();
        run_frame("hold", 1'b1);
        chk("hold_class", longint'(f_class), m_class);
        chk("hold_score", longint'(f_score), m_score[m_class]);

        // Reset in the middle of a scan, then a clean rescan of the same frame.
        fill(6);
        model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (cell_addr == 10'd500) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("midrst_reached_addr500", longint'(found), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_valid", longint'(result_valid), 0);
        chk("midrst_addr", longint'(cell_addr), 0);
        run_frame("rescan", 1'b0);
        chk("rescan_class", longint'(f_class), m_class);
        chk("rescan_score", longint'(f_score), m_score[m_class]);
        chk("rescan_conf", longint'(f_conf), longint'(m_conf));

        // Random frames against the reference model.
        for (int r = 0; r < 4; r++) begin
            fill(5 + (r % 2));
            model();
            run_frame($sformatf("rnd%0d", r), 1'b0);
            chk($sformatf("rnd%0d_class", r), longint'(f_class), m_class);
            chk($sformatf("rnd%0d_score", r), longint'(f_score), m_score[m_class]);
            chk($sformatf("rnd%0d_conf", r), longint'(f_conf), longint'(m_conf));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
